siso_arbiter: RTL and testbench
===============================

# siso_arbiter

Two-requester serial transmit scheduler for the SISO shift path. It accepts WIDTH-bit words from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. Each granted word is loaded into an internal shift register and driven MSB-first on a single serial line, one bit per clock. It sits between parallel producers and the serial shift datapath, and owns all loading and shifting of that register.

## Interface
- WIDTH, 8, bits per frame; legal range 2..32
- GAP, 1, idle cycles inserted after each frame's last bit; legal range 0..15

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; asserted when 0
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WIDTH  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WIDTH  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle when valid&ready
- serial_out  out  1  serial bit, MSB first; 0 when no frame is active
- frame_active  out  1  high while serial_out carries a frame bit
- frame_src  out  1  source of the current or last frame (0 or 1)
- frame_done  out  1  one-cycle pulse after a frame's last bit

## Operation
- FSM states: IDLE, SHIFT, PAUSE. All state, outputs and counters are registered, except ready.
- Reset (rst=0) clears the following immediately and asynchronously: state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0, last_grant=1, serial_out=0, frame_active=0, frame_src=0, frame_done=0. The ready outputs are 0 while rst=0.
- IDLE, grant (combinational from the valid inputs and last_grant):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester with index != last_grant is granted.
  - Neither valid: no grant; both ready outputs are 0.
- req0_ready is 1 only in IDLE when requester 0 holds the grant; req1_ready likewise. Both ready outputs are 0 in SHIFT and PAUSE.
- Requesters hold valid and data stable until they see ready. The block never accepts a word outside IDLE.
- On an accept edge (granted valid & ready):
  - shift_reg <= granted data, bit_cnt <= 0, last_grant <= granted index, frame_src <= granted index.
  - state <= SHIFT.
- SHIFT:
  - serial_out = shift_reg[WIDTH-1] and frame_active = 1, both registered from the load and shift edges.
  - Each edge: shift_reg <= {shift_reg[WIDTH-2:0],0} and bit_cnt increments.
  - At bit_cnt == WIDTH-1 the next state is PAUSE if GAP>0, else IDLE. On that edge frame_done <= 1, frame_active <= 0 and serial_out <= 0.
- PAUSE: lasts GAP cycles, counted by gap_cnt, then goes to IDLE. No accept is possible during PAUSE.
- frame_done is high for exactly one cycle per completed frame. A frame aborted by reset produces no frame_done.

## Timing
- An accept at edge k puts the MSB on serial_out for the cycle between edges k and k+1. Bit i (counting from the MSB) occupies the cycle starting at edge k+i.
- frame_active is high for exactly WIDTH consecutive cycles per frame.
- frame_done is high during cycle k+WIDTH.
- Frame period: the minimum spacing between accept edges is WIDTH+GAP+1 cycles, because one IDLE cycle is needed for the handshake. frame_active is therefore low for at least GAP+1 cycles between frames.
- Ready is combinational from valid in IDLE. There is no combinational path from any input to serial_out, frame_active, frame_src or frame_done.
- Reset mid-frame: outputs go to their reset values without waiting for a clock edge. After rst returns to 1, the first grant on simultaneous valid goes to requester 0, because last_grant=1.
- The shift register wraps with no carry-in: vacated LSBs fill with 0 and are never driven onto serial_out.

## Test plan
- Single word: req0 sends 8'hA5, WIDTH=8, GAP=1 -> serial_out 1,0,1,0,0,1,0,1 over 8 cycles, frame_src=0, frame_done pulses one cycle later, and the next accept is no earlier than 10 cycles after the first.
- Simultaneous request from reset: req0=8'h81 and req1=8'h7E both valid -> req0 is served first, then req1. Only one ready is high in any cycle, and ready is never high outside IDLE.
- Fairness: both requesters hold valid continuously for 6 words -> frame_src sequence 0,1,0,1,0,1.
- Reset mid-frame: assert rst=0 during bit 3 of req1's 8'hF0 -> serial_out, frame_active and frame_done go to 0 immediately, and no frame_done follows. After release, with both valid, req0 is granted first.
- GAP=0 back-to-back: req1 sends 8'hFF then 8'h00 -> the two 8-cycle frame_active windows are separated by exactly 1 low cycle, and the second frame's serial_out is all 0s.
- Idle hold: no valid for 20 cycles -> serial_out=0, frame_active=0, both ready=0, state remains IDLE.

Source files
------------

// File: rtl/siso_arbiter.sv
// Round-robin scheduler for two parallel requesters feeding one MSB-first serial line.
// A granted word is shifted out over WIDTH cycles, followed by GAP idle cycles.
module siso_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             frame_src,
  output logic             frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PAUSE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last_grant;
  logic             gnt_vld, gnt_idx, accept, last_bit, gap_end;
  logic [WIDTH-1:0] gnt_data;

  // Grant favours the requester that was not served last when both are valid.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_idx = 1'b0;
    if (req0_valid && req1_valid) gnt_idx = ~last_grant;
    else if (req1_valid)          gnt_idx = 1'b1;
    gnt_data   = gnt_idx ? req1_data : req0_data;
    accept     = (state == IDLE) && gnt_vld;
    req0_ready = rst && accept && !gnt_idx;
    req1_ready = rst && accept && gnt_idx;
    last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
    gap_end    = (gap_cnt == 4'(GAP - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = (GAP > 0) ? PAUSE : IDLE;
      PAUSE:   if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // serial_out is loaded with the MSB on the accept edge, so each later edge
  // presents the bit one below the current register MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      last_grant   <= 1'b1;
      serial_out   <= 1'b0;
      frame_active <= 1'b0;
      frame_src    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg    <= gnt_data;
            bit_cnt      <= '0;
            last_grant   <= gnt_idx;
            frame_src    <= gnt_idx;
            serial_out   <= gnt_data[WIDTH-1];
            frame_active <= 1'b1;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          if (last_bit) begin
            frame_done   <= 1'b1;
            frame_active <= 1'b0;
            serial_out   <= 1'b0;
            gap_cnt      <= '0;
          end else begin
            bit_cnt    <= bit_cnt + CNT_W'(1);
            serial_out <= shift_reg[WIDTH-2];
          end
        end
        PAUSE: gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_arbiter.sv
// Directed bench for siso_arbiter: GAP=1 instance for most scenarios, GAP=0 instance
// for back-to-back frames.
module tb_siso_arbiter;

  logic       clk;
  logic       rst;
  logic       v0_a, v1_a, r0_a, r1_a, so_a, fa_a, fs_a, fd_a;
  logic [7:0] d0_a, d1_a;
  logic       v0_b, v1_b, r0_b, r1_b, so_b, fa_b, fs_b, fd_b;
  logic [7:0] d0_b, d1_b;

  int tests = 0;
  int fails = 0;
  int n;

  siso_arbiter #(.WIDTH(8), .GAP(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0_a), .req0_data(d0_a), .req0_ready(r0_a),
    .req1_valid(v1_a), .req1_data(d1_a), .req1_ready(r1_a),
    .serial_out(so_a), .frame_active(fa_a), .frame_src(fs_a), .frame_done(fd_a)
  );

  siso_arbiter #(.WIDTH(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0_b), .req0_data(d0_b), .req0_ready(r0_b),
    .req1_valid(v1_b), .req1_data(d1_b), .req1_ready(r1_b),
    .serial_out(so_b), .frame_active(fa_b), .frame_src(fs_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input bit sel, input string tag, output int cyc);
    logic rdy;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
      rdy = sel ? (r0_b | r1_b) : (r0_a | r1_a);
    end
    check({tag, "_rdy"}, 32'(rdy), 1);
    check({tag, "_onehot"}, 32'(sel ? (r0_b & r1_b) : (r0_a & r1_a)), 0);
  endtask

  // Called just after the accept edge; returns at the frame_done sample point.
  task automatic watch_frame(input bit sel, input logic [7:0] data, input logic src,
                             input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check({tag, "_so"}, 32'(sel ? so_b : so_a), 32'(data[7-i]));
      check({tag, "_fa"}, 32'(sel ? fa_b : fa_a), 1);
      check({tag, "_fd_mid"}, 32'(sel ? fd_b : fd_a), 0);
      check({tag, "_rdy_busy"}, 32'(sel ? (r0_b | r1_b) : (r0_a | r1_a)), 0);
      if (i == 0) check({tag, "_src"}, 32'(sel ? fs_b : fs_a), 32'(src));
    end
    @(negedge clk);
    check({tag, "_fd"}, 32'(sel ? fd_b : fd_a), 1);
    check({tag, "_fa_end"}, 32'(sel ? fa_b : fa_a), 0);
    check({tag, "_so_end"}, 32'(sel ? so_b : so_a), 0);
    if (!sel) check({tag, "_rdy_pause"}, 32'(r0_a | r1_a), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_fa", 32'(fa_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    v0_a = 1'b1; v1_a = 1'b1; d0_a = 8'h00; d1_a = 8'h00;
    v0_b = 1'b0; v1_b = 1'b0; d0_b = 8'h00; d1_b = 8'h00;
    #1 rst = 1'b0;
    #2;
    check("rst_so", 32'(so_a), 0);
    check("rst_fa0", 32'(fa_a), 0);
    check("rst_fs", 32'(fs_a), 0);
    check("rst_fd", 32'(fd_a), 0);
    check("rst_rdy0", 32'(r0_a), 0);
    check("rst_rdy1", 32'(r1_a), 0);
    v0_a = 1'b0; v1_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single word A5, then a second word to measure the accept spacing
    @(posedge clk); #1;
    v0_a = 1'b1; d0_a = 8'hA5;
    wait_ready(0, "t1_a", n);
    check("t1_a_r0", 32'(r0_a), 1);
    @(posedge clk); #1;
    d0_a = 8'hC3;
    watch_frame(0, 8'hA5, 1'b0, "t1_a5");
    wait_ready(0, "t1_b", n);
    check("t1_spacing", 32'(n), 1);
    check("t1_b_r0", 32'(r0_a), 1);
    @(posedge clk); #1;
    v0_a = 1'b0;
    watch_frame(0, 8'hC3, 1'b0, "t1_c3");

    // Simultaneous request straight out of reset
    do_reset();
    @(posedge clk); #1;
    v0_a = 1'b1; d0_a = 8'h81; v1_a = 1'b1; d1_a = 8'h7E;
    wait_ready(0, "t2_a", n);
    check("t2_a_r0", 32'(r0_a), 1);
    @(posedge clk); #1;
    v0_a = 1'b0;
    watch_frame(0, 8'h81, 1'b0, "t2_81");
    wait_ready(0, "t2_b", n);
    check("t2_b_r1", 32'(r1_a), 1);
    @(posedge clk); #1;
    v1_a = 1'b0;
    watch_frame(0, 8'h7E, 1'b1, "t2_7e");

    // Fairness: both requesters continuously valid for 6 words
    do_reset();
    @(posedge clk); #1;
    v0_a = 1'b1; d0_a = 8'h10; v1_a = 1'b1; d1_a = 8'h20;
    for (int w = 0; w < 6; w++) begin
      logic       src;
      logic [7:0] exp_d;
      src   = 1'(w % 2);
      exp_d = src ? d1_a : d0_a;
      wait_ready(0, "t3", n);
      if (w > 0) check("t3_spacing", 32'(n), 1);
      check("t3_r0", 32'(r0_a), 32'(!src));
      check("t3_r1", 32'(r1_a), 32'(src));
      @(posedge clk); #1;
      if (src) d1_a = d1_a + 8'd1;
      else     d0_a = d0_a + 8'd1;
      if (w == 5) begin v0_a = 1'b0; v1_a = 1'b0; end
      watch_frame(0, exp_d, src, "t3_frame");
    end

    // Reset during bit 3 of requester 1's F0 frame
    @(posedge clk); #1;
    v1_a = 1'b1; d1_a = 8'hF0;
    wait_ready(0, "t4_a", n);
    check("t4_a_r1", 32'(r1_a), 1);
    @(posedge clk); #1;
    v1_a = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_bit3_so", 32'(so_a), 1);
    check("t4_bit3_fa", 32'(fa_a), 1);
    #1;
    rst = 1'b0;
    v0_a = 1'b1; d0_a = 8'h5A; v1_a = 1'b1; d1_a = 8'hA5;
    #1;
    check("t4_abort_so", 32'(so_a), 0);
    check("t4_abort_fa", 32'(fa_a), 0);
    check("t4_abort_fd", 32'(fd_a), 0);
    check("t4_abort_rdy", 32'(r0_a | r1_a), 0);
    @(negedge clk);
    check("t4_hold_fd", 32'(fd_a), 0);
    rst = 1'b1;
    #1;
    check("t4_rel_r0", 32'(r0_a), 1);
    check("t4_rel_r1", 32'(r1_a), 0);
    @(posedge clk); #1;
    v0_a = 1'b0;
    watch_frame(0, 8'h5A, 1'b0, "t4_5a");
    wait_ready(0, "t4_b", n);
    check("t4_b_r1", 32'(r1_a), 1);
    @(posedge clk); #1;
    v1_a = 1'b0;
    watch_frame(0, 8'hA5, 1'b1, "t4_a5");

    // GAP=0 back-to-back frames on the second instance
    @(posedge clk); #1;
    v1_b = 1'b1; d1_b = 8'hFF;
    wait_ready(1, "t5_a", n);
    check("t5_a_r1", 32'(r1_b), 1);
    @(posedge clk); #1;
    d1_b = 8'h00;
    watch_frame(1, 8'hFF, 1'b1, "t5_ff");
    check("t5_gap_r1", 32'(r1_b), 1);
    @(posedge clk); #1;
    v1_b = 1'b0;
    watch_frame(1, 8'h00, 1'b1, "t5_00");

    // Idle hold
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t6_so", 32'(so_a), 0);
      check("t6_fa", 32'(fa_a), 0);
      check("t6_rdy", 32'(r0_a | r1_a), 0);
    end
    v0_a = 1'b1; d0_a = 8'h33;
    #1;
    check("t6_idle_r0", 32'(r0_a), 1);
    v0_a = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
